// File: rtl/regfile_bypass_sb.sv
// regfile_bypass_sb
//   Multi-port register file with write-to-read bypass and a pending-write
//   scoreboard. Decode reserves a destination at issue (rsv_*), writeback
//   clears the reservation (write_*), and each read port reports whether its
//   operand is usable this cycle so hazard logic can stall.
//
// Ports
//   clk         clock
//   rst         asynchronous active-low reset
//   read_sel    NUM_READ packed selects, port i at [i*SEL_W +: SEL_W]
//   read_data   NUM_READ packed data words, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   read_ready  per-port operand valid this cycle
//   write_sel   write register select
//   write_data  write data
//   write_en    write strobe (also clears the pending bit of write_sel)
//   rsv_sel     register to reserve
//   rsv_en      reservation request
//   rsv_ack     reservation granted this cycle (combinational)
//   pend_cnt    number of registers currently pending
//   err         sticky protocol error (write to a non-pending register, SB_STRICT=1)
//
// Build option
//   RF_ZERO_REG_EN  when defined, r0 is hardwired to zero: reads 0 and ready,
//                   writes dropped without error, reservations acked but not
//                   tracked.

module regfile_bypass_sb #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 8,
    parameter int NUM_READ   = 2,
    parameter int SB_STRICT  = 1,
    localparam int SEL_W     = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_READ*SEL_W-1:0]      read_sel,
    output logic [NUM_READ*DATA_WIDTH-1:0] read_data,
    output logic [NUM_READ-1:0]            read_ready,
    input  logic [SEL_W-1:0]               write_sel,
    input  logic [DATA_WIDTH-1:0]          write_data,
    input  logic                           write_en,
    input  logic [SEL_W-1:0]               rsv_sel,
    input  logic                           rsv_en,
    output logic                           rsv_ack,
    output logic [SEL_W:0]                 pend_cnt,
    output logic                           err
);

`ifdef RF_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   pending_q, pending_d;
    logic [SEL_W:0]        pend_cnt_q, pend_cnt_d;
    logic                  err_q, err_d;

    logic wr_eff;     // write that actually lands in storage
    logic wr_clr;     // write retires a pending reservation
    logic rsv_set;    // grant that creates a tracked reservation
    logic cnt_inc;
    logic cnt_dec;

    // Read ports: hardwired r0 first, then bypass of the in-flight write,
    // then storage.
    always_comb begin
        read_data  = '0;
        read_ready = '0;
        for (int unsigned i = 0; i < NUM_READ; i++) begin
            logic [SEL_W-1:0] sel;
            sel = read_sel[i*SEL_W +: SEL_W];
            if (ZERO_EN && sel == '0) begin
                read_data[i*DATA_WIDTH +: DATA_WIDTH] = '0;
                read_ready[i]                         = 1'b1;
            end else if (write_en && write_sel == sel) begin
                read_data[i*DATA_WIDTH +: DATA_WIDTH] = write_data;
                read_ready[i]                         = 1'b1;
            end else begin
                read_data[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[sel];
                read_ready[i]                         = !pending_q[sel];
            end
        end
    end

    // r0 is never marked pending when hardwired, so the grant rule needs no
    // special case for it.
    assign rsv_ack = rsv_en && (!pending_q[rsv_sel] || (write_en && write_sel == rsv_sel));

    always_comb begin
        regs_d     = regs_q;
        pending_d  = pending_q;
        pend_cnt_d = pend_cnt_q;
        err_d      = err_q;

        wr_eff  = write_en && !(ZERO_EN && write_sel == '0);
        wr_clr  = wr_eff && pending_q[write_sel];
        rsv_set = rsv_ack && !(ZERO_EN && rsv_sel == '0);

        // A set on an already-pending register only happens when the same
        // register is being written, so set and clear cancel there.
        cnt_inc = rsv_set && !pending_q[rsv_sel];
        cnt_dec = wr_clr && !(rsv_set && rsv_sel == write_sel);

        if (wr_eff) begin
            regs_d[write_sel] = write_data;
        end
        // Clear before set: a write and a new reservation on the same
        // register leave it pending for the new producer.
        if (wr_clr) begin
            pending_d[write_sel] = 1'b0;
        end
        if (rsv_set) begin
            pending_d[rsv_sel] = 1'b1;
        end
        pend_cnt_d = pend_cnt_q + (SEL_W+1)'(cnt_inc) - (SEL_W+1)'(cnt_dec);

        if ((SB_STRICT != 0) && wr_eff && !pending_q[write_sel]
            && !(rsv_ack && rsv_sel == write_sel)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q     <= '{default: '0};
            pending_q  <= '0;
            pend_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            pending_q  <= pending_d;
            pend_cnt_q <= pend_cnt_d;
            err_q      <= err_d;
        end
    end

    assign pend_cnt = pend_cnt_q;
    assign err      = err_q;

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Testbench for regfile_bypass_sb (default 8x16, two read ports).
// A strict instance is checked in full; a second instance with SB_STRICT=0
// shares all inputs and must never raise err.

module tb_regfile_bypass_sb;

    localparam int DW = 16;
    localparam int NR = 8;
    localparam int SW = 3;

`ifdef RF_ZERO_REG_EN
    localparam bit ZERO = 1'b1;
`else
    localparam bit ZERO = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [SW-1:0] rs0, rs1;
    logic [2*SW-1:0] read_sel;
    logic [2*DW-1:0] read_data, read_data_lx;
    logic [1:0]    read_ready, read_ready_lx;
    logic [SW-1:0] write_sel;
    logic [DW-1:0] write_data;
    logic          write_en;
    logic [SW-1:0] rsv_sel;
    logic          rsv_en;
    logic          rsv_ack, rsv_ack_lx;
    logic [SW:0]   pend_cnt, pend_cnt_lx;
    logic          err, err_lx;

    assign read_sel = {rs1, rs0};

    always #5 clk = ~clk;

    regfile_bypass_sb #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_READ(2), .SB_STRICT(1)) u_dut (
        .clk(clk), .rst(rst), .read_sel(read_sel), .read_data(read_data),
        .read_ready(read_ready), .write_sel(write_sel), .write_data(write_data),
        .write_en(write_en), .rsv_sel(rsv_sel), .rsv_en(rsv_en), .rsv_ack(rsv_ack),
        .pend_cnt(pend_cnt), .err(err)
    );

    regfile_bypass_sb #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_READ(2), .SB_STRICT(0)) u_dut_lax (
        .clk(clk), .rst(rst), .read_sel(read_sel), .read_data(read_data_lx),
        .read_ready(read_ready_lx), .write_sel(write_sel), .write_data(write_data),
        .write_en(write_en), .rsv_sel(rsv_sel), .rsv_en(rsv_en), .rsv_ack(rsv_ack_lx),
        .pend_cnt(pend_cnt_lx), .err(err_lx)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] m_mem [NR];
    bit            m_pend [NR];
    bit            m_err;

    task automatic m_reset();
        for (int r = 0; r < NR; r++) begin
            m_mem[r]  = '0;
            m_pend[r] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    function automatic logic [DW-1:0] m_rd(input logic [SW-1:0] s);
        if (ZERO && s == 0) return '0;
        if (write_en && write_sel == s) return write_data;
        return m_mem[s];
    endfunction

    function automatic logic m_rdy(input logic [SW-1:0] s);
        if (ZERO && s == 0) return 1'b1;
        return !m_pend[s] || (write_en && write_sel == s);
    endfunction

    function automatic logic m_ack();
        return rsv_en && (!m_pend[rsv_sel] || (write_en && write_sel == rsv_sel));
    endfunction

    function automatic int m_cnt();
        int c = 0;
        for (int r = 0; r < NR; r++) c += int'(m_pend[r]);
        return c;
    endfunction

    task automatic m_update();
        logic ack, wr;
        ack = m_ack();
        wr  = write_en && !(ZERO && write_sel == 0);
        if (wr && !m_pend[write_sel] && !(ack && rsv_sel == write_sel)) m_err = 1'b1;
        if (wr) begin
            m_mem[write_sel]  = write_data;
            m_pend[write_sel] = 1'b0;
        end
        if (ack && !(ZERO && rsv_sel == 0)) m_pend[rsv_sel] = 1'b1;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic we, input logic [SW-1:0] ws, input logic [DW-1:0] wd,
                         input logic [SW-1:0] s0, input logic [SW-1:0] s1,
                         input logic re, input logic [SW-1:0] rs);
        write_en = we; write_sel = ws; write_data = wd;
        rs0 = s0; rs1 = s1; rsv_en = re; rsv_sel = rs;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " rd0"},  {16'h0, read_data[15:0]},  {16'h0, m_rd(rs0)});
        chk({tag, " rd1"},  {16'h0, read_data[31:16]}, {16'h0, m_rd(rs1)});
        chk({tag, " rdy"},  {30'h0, read_ready},       {30'h0, m_rdy(rs1), m_rdy(rs0)});
        chk({tag, " ack"},  {31'h0, rsv_ack},          {31'h0, m_ack()});
        chk({tag, " cnt"},  {28'h0, pend_cnt},         32'(m_cnt()));
        chk({tag, " err"},  {31'h0, err},              {31'h0, m_err});
    endtask

    task automatic tick();
        chk("lax err", {31'h0, err_lx}, 32'h0);
        @(posedge clk);
        m_update();
        #1;
    endtask

    typedef struct {
        logic          we;
        logic [SW-1:0] ws;
        logic [DW-1:0] wd;
        logic [SW-1:0] s0, s1;
        logic          re;
        logic [SW-1:0] rs;
        logic [DW-1:0] rd0, rd1;
        logic [1:0]    rdy;
        logic          ack;
        logic [SW:0]   cnt;
        logic          err;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //              we ws wd        s0 s1 re rs  rd0      rd1      rdy    ack cnt err
        tbl[0]  = '{1'b1, 3, 16'hBEEF, 3, 1, 1'b0, 0, 16'hBEEF, 16'h0000, 2'b11, 1'b0, 0, 1'b0};
        tbl[1]  = '{1'b0, 0, 16'h0000, 3, 5, 1'b0, 0, 16'hBEEF, 16'h0000, 2'b11, 1'b0, 0, 1'b1};
        tbl[2]  = '{1'b1, 5, 16'h1234, 3, 5, 1'b0, 0, 16'hBEEF, 16'h1234, 2'b11, 1'b0, 0, 1'b1};
        tbl[3]  = '{1'b0, 0, 16'h0000, 2, 5, 1'b1, 2, 16'h0000, 16'h1234, 2'b11, 1'b1, 0, 1'b1};
        tbl[4]  = '{1'b0, 0, 16'h0000, 2, 3, 1'b1, 2, 16'h0000, 16'hBEEF, 2'b10, 1'b0, 1, 1'b1};
        tbl[5]  = '{1'b1, 2, 16'h00AA, 2, 2, 1'b0, 0, 16'h00AA, 16'h00AA, 2'b11, 1'b0, 1, 1'b1};
        tbl[6]  = '{1'b0, 0, 16'h0000, 2, 3, 1'b1, 4, 16'h00AA, 16'hBEEF, 2'b11, 1'b1, 0, 1'b1};
        tbl[7]  = '{1'b1, 4, 16'h5555, 4, 2, 1'b1, 4, 16'h5555, 16'h00AA, 2'b11, 1'b1, 1, 1'b1};
        tbl[8]  = '{1'b0, 0, 16'h0000, 4, 5, 1'b0, 0, 16'h5555, 16'h1234, 2'b10, 1'b0, 1, 1'b1};
        tbl[9]  = '{1'b1, 4, 16'h0F0F, 6, 4, 1'b1, 6, 16'h0000, 16'h0F0F, 2'b11, 1'b1, 1, 1'b1};
        tbl[10] = '{1'b0, 0, 16'h0000, 6, 4, 1'b1, 7, 16'h0000, 16'h0F0F, 2'b10, 1'b1, 1, 1'b1};
        tbl[11] = '{1'b0, 0, 16'h0000, 7, 1, 1'b0, 0, 16'h0000, 16'h0000, 2'b10, 1'b0, 2, 1'b1};

        // Reset state, ack follows rsv_en while cleared.
        rst = 1'b0;
        drive(1'b0, 0, 16'h0, 3, 6, 1'b1, 3);
        m_reset();
        #2;
        chk("reset cnt", {28'h0, pend_cnt}, 32'h0);
        chk("reset err", {31'h0, err}, 32'h0);
        chk("reset rdy", {30'h0, read_ready}, 32'h3);
        chk("reset ack", {31'h0, rsv_ack}, 32'h1);
        chk("reset rd0", {16'h0, read_data[15:0]}, 32'h0);
        rsv_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].we, tbl[i].ws, tbl[i].wd, tbl[i].s0, tbl[i].s1, tbl[i].re, tbl[i].rs);
            #2;
            chk($sformatf("tbl%0d rd0", i), {16'h0, read_data[15:0]},  {16'h0, tbl[i].rd0});
            chk($sformatf("tbl%0d rd1", i), {16'h0, read_data[31:16]}, {16'h0, tbl[i].rd1});
            chk($sformatf("tbl%0d rdy", i), {30'h0, read_ready},       {30'h0, tbl[i].rdy});
            chk($sformatf("tbl%0d ack", i), {31'h0, rsv_ack},          {31'h0, tbl[i].ack});
            chk($sformatf("tbl%0d cnt", i), {28'h0, pend_cnt},         {28'h0, tbl[i].cnt});
            chk($sformatf("tbl%0d err", i), {31'h0, err},              {31'h0, tbl[i].err});
            tick();
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), SW'($urandom_range(0, NR-1)), DW'($urandom),
                  SW'($urandom_range(0, NR-1)), SW'($urandom_range(0, NR-1)),
                  1'($urandom_range(0, 1)), SW'($urandom_range(0, NR-1)));
            #2;
            check_model($sformatf("rnd%0d", i));
            tick();
        end

        // Asynchronous reset mid-cycle discards everything.
        drive(1'b0, 0, 16'h0, 0, 0, 1'b0, 0);
        #2;
        rst = 1'b0;
        #1;
        m_reset();
        chk("mid-rst cnt", {28'h0, pend_cnt}, 32'h0);
        chk("mid-rst err", {31'h0, err}, 32'h0);
        for (int r = 0; r < NR; r++) begin
            rs0 = SW'(r);
            rs1 = SW'(r);
            #1;
            chk($sformatf("mid-rst r%0d data", r), {16'h0, read_data[15:0]}, 32'h0);
            chk($sformatf("mid-rst r%0d rdy", r), {30'h0, read_ready}, 32'h3);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Strict error: reserved writes and write+reserve are clean,
        // an unreserved write sets err and it sticks.
        drive(1'b0, 0, 16'h0, 1, 3, 1'b1, 1);
        #2; chk("s1 ack", {31'h0, rsv_ack}, 32'h1); chk("s1 err", {31'h0, err}, 32'h0);
        tick();
        drive(1'b1, 1, 16'h0077, 1, 3, 1'b0, 0);
        #2; chk("s2 cnt", {28'h0, pend_cnt}, 32'h1); chk("s2 rd0", {16'h0, read_data[15:0]}, 32'h77);
        tick();
        drive(1'b1, 3, 16'h0033, 1, 3, 1'b1, 3);
        #2; chk("s3 ack", {31'h0, rsv_ack}, 32'h1); chk("s3 cnt", {28'h0, pend_cnt}, 32'h0);
        tick();
        drive(1'b0, 0, 16'h0, 3, 1, 1'b0, 0);
        #2; chk("s4 cnt", {28'h0, pend_cnt}, 32'h1); chk("s4 err", {31'h0, err}, 32'h0);
        chk("s4 rdy", {30'h0, read_ready}, 32'h2); chk("s4 rd0", {16'h0, read_data[15:0]}, 32'h33);
        tick();
        drive(1'b1, 6, 16'h0066, 6, 1, 1'b0, 0);
        #2; chk("s5 err", {31'h0, err}, 32'h0);
        tick();
        drive(1'b0, 0, 16'h0, 6, 1, 1'b0, 0);
        for (int k = 0; k < 3; k++) begin
            #2; chk($sformatf("s6 err sticky %0d", k), {31'h0, err}, 32'h1);
            tick();
        end

        // r0: hardwired to zero when the option is built in, ordinary otherwise.
        drive(1'b1, 0, 16'hFFFF, 0, 1, 1'b0, 0);
        #2;
        chk("z1 rd0", {16'h0, read_data[15:0]}, ZERO ? 32'h0 : 32'hFFFF);
        chk("z1 rdy", {30'h0, read_ready}, 32'h3);
        tick();
        drive(1'b0, 0, 16'h0, 0, 1, 1'b1, 0);
        #2;
        chk("z2 rd0", {16'h0, read_data[15:0]}, ZERO ? 32'h0 : 32'hFFFF);
        chk("z2 ack", {31'h0, rsv_ack}, 32'h1);
        chk("z2 cnt", {28'h0, pend_cnt}, 32'h1);
        tick();
        drive(1'b0, 0, 16'h0, 0, 1, 1'b0, 0);
        #2;
        chk("z3 cnt", {28'h0, pend_cnt}, ZERO ? 32'h1 : 32'h2);
        chk("z3 rdy", {30'h0, read_ready}, ZERO ? 32'h3 : 32'h2);
        check_model("z3");
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
